// File: rtl/mem_responder.sv
// mem_responder: arbitrated, fixed-latency word memory serving the fetch and load/store ports
module mem_responder #(
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_ifu_reqValid,
    input  logic [31:0] i_ifu_addr,
    output logic        o_ifu_respValid,
    output logic [31:0] o_ifu_rdata,
    input  logic        i_lsu_reqValid,
    input  logic        i_lsu_wen,
    input  logic [3:0]  i_lsu_wbmask,
    input  logic [31:0] i_lsu_wdata,
    input  logic [31:0] i_lsu_addr,
    output logic        o_lsu_respValid,
    output logic [31:0] o_lsu_rdata,
    output logic        o_busy,
    output logic        o_fault
);
    localparam int          AW    = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN  = 32'(4 * MEM_WORDS);
    localparam logic [15:0] CLOAD = (LATENCY > 1) ? 16'(LATENCY - 2) : 16'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        r_state, w_next;
    logic [15:0]   r_cnt;
    logic          r_lsu, r_wen, r_fault;
    logic [3:0]    r_mask;
    logic [31:0]   r_wdata, r_addr, r_ifu_rdata, r_lsu_rdata;
    logic [31:0]   r_mem [MEM_WORDS];
    logic          w_accept, w_enter, w_lsu, w_wen, w_inr;
    logic [3:0]    w_mask, w_bmask;
    logic [31:0]   w_wdata, w_addr, w_off, w_data, w_rword;
    logic [1:0]    w_sh;
    logic [AW-1:0] w_idx;

    // In IDLE the live inputs drive the datapath so a LATENCY==1 access can complete on its accept edge
    always_comb begin
        w_accept = r_state == IDLE && (i_lsu_reqValid || i_ifu_reqValid);
        w_lsu    = r_state == IDLE ? i_lsu_reqValid : r_lsu;
        w_wen    = r_state == IDLE ? i_lsu_reqValid && i_lsu_wen : r_wen;
        w_mask   = r_state == IDLE ? i_lsu_wbmask : r_mask;
        w_wdata  = r_state == IDLE ? i_lsu_wdata : r_wdata;
        w_addr   = r_state == IDLE ? (i_lsu_reqValid ? i_lsu_addr : i_ifu_addr) : r_addr;
        w_off    = w_addr - MEM_BASE;
        w_inr    = w_off < SPAN;
        w_idx    = w_off[AW+1:2];
        w_sh     = w_addr[1:0];
        w_bmask  = w_mask << w_sh;
        w_data   = w_wdata << {w_sh, 3'b000};
        w_rword  = r_mem[w_idx] >> {w_sh, 3'b000};
        w_enter  = (r_state == WAIT && r_cnt == 16'd0) || (w_accept && LATENCY == 1);
    end

    // Next state: accept in IDLE, count down in WAIT, single-cycle RESP
    always_comb begin
        w_next = r_state == RESP ? IDLE :
                 r_state == WAIT ? (r_cnt == 16'd0 ? RESP : WAIT) :
                 w_accept        ? (LATENCY == 1 ? RESP : WAIT) : IDLE;
    end

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Payload capture, latency counter and response data registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt       <= 16'd0;
            r_lsu       <= 1'b0;
            r_wen       <= 1'b0;
            r_mask      <= 4'd0;
            r_wdata     <= 32'd0;
            r_addr      <= 32'd0;
            r_fault     <= 1'b0;
            r_ifu_rdata <= 32'd0;
            r_lsu_rdata <= 32'd0;
        end else begin
            if (w_accept) begin
                r_cnt   <= CLOAD;
                r_lsu   <= w_lsu;
                r_wen   <= w_wen;
                r_mask  <= w_mask;
                r_wdata <= w_wdata;
                r_addr  <= w_addr;
            end else if (r_state == WAIT && r_cnt != 16'd0) begin
                r_cnt <= r_cnt - 16'd1;
            end
            if (w_enter) begin
                r_fault <= !w_inr;
                if (w_lsu) r_lsu_rdata <= (w_inr && !w_wen) ? w_rword : 32'd0;
                else       r_ifu_rdata <= w_inr ? w_rword : 32'd0;
            end
        end
    end

    // Byte-lane store into the array; lanes shifted past byte 3 are simply absent from w_bmask
    always_ff @(posedge i_clock) begin
        if (!i_reset && w_enter && w_wen && w_inr)
            for (int b = 0; b < 4; b++)
                if (w_bmask[b]) r_mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
    end

    assign o_ifu_respValid = r_state == RESP && !r_lsu;
    assign o_lsu_respValid = r_state == RESP && r_lsu;
    assign o_ifu_rdata     = r_ifu_rdata;
    assign o_lsu_rdata     = r_lsu_rdata;
    assign o_busy          = r_state != IDLE;
    assign o_fault         = r_state == RESP && r_fault;
endmodule
